// File: rtl/modinv_invert_loop_ctrl_pkg.sv
// Shared definitions for the modular-inverse loop controller: FSM states,
// helper op codes and a constant-evaluable clog2.
package modinv_invert_loop_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMP_START = 3'd1,
    ST_CMP_WAIT  = 3'd2,
    ST_DECIDE    = 3'd3,
    ST_OP_START  = 3'd4,
    ST_OP_WAIT   = 3'd5
  } state_t;

  localparam logic [1:0] OP_HALVE_U = 2'd0;
  localparam logic [1:0] OP_HALVE_V = 2'd1;
  localparam logic [1:0] OP_SUB_U_V = 2'd2;
  localparam logic [1:0] OP_SUB_V_U = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/modinv_invert_loop_ctrl_op_decode.sv
// Flag priority decode for one binary-GCD step: done when v==1, otherwise
// picks the halving or subtract-and-halve op.
module modinv_invert_op_decode
  import modinv_invert_loop_ctrl_pkg::*;
(
  input  logic       u_gt_v,
  input  logic       v_eq_1,
  input  logic       u_is_even,
  input  logic       v_is_even,
  output logic       done,
  output logic [1:0] op_code
);

  always_comb begin
    done    = 1'b0;
    op_code = OP_HALVE_U;
    if (v_eq_1) begin
      done = 1'b1;
    end else if (u_is_even) begin
      op_code = OP_HALVE_U;
    end else if (v_is_even) begin
      op_code = OP_HALVE_V;
    end else if (u_gt_v) begin
      op_code = OP_SUB_U_V;
    end else begin
      op_code = OP_SUB_V_U;
    end
  end

endmodule

// File: rtl/modinv_invert_loop_ctrl.sv
// Iteration controller for the binary modular-inverse loop: sequences compare
// and op helpers via one-cycle start pulses and counts completed ops in k.
// Optional iteration-limit abort is enabled with `define MODINV_ITER_LIMIT_EN.
//
// Handshake: a helper accepts a request when its *_ena pulse is high for one
// cycle while its *_rdy is high; the helper then drops *_rdy (it is ignored in
// the cycle right after the pulse) and raises it again when finished.
module modinv_invert_loop_ctrl
  import modinv_invert_loop_ctrl_pkg::*;
#(
  parameter int  OPERAND_NUM_WORDS = 8,
  localparam int ITER_LIMIT        = 64 * OPERAND_NUM_WORDS,
  localparam int K_BITS            = clog2(ITER_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  output logic              rdy,
  output logic [K_BITS-1:0] k,
  output logic              err,
  output logic              cmp_ena,
  input  logic              cmp_rdy,
  input  logic              u_gt_v,
  input  logic              v_eq_1,
  input  logic              u_is_even,
  input  logic              v_is_even,
  output logic              op_ena,
  output logic [1:0]        op_code,
  input  logic              op_rdy,
  output logic [2:0]        state_dbg
);

  localparam logic [K_BITS-1:0] K_MAX = {K_BITS{1'b1}};

  state_t            state_q, state_d;
  logic [K_BITS-1:0] k_q, k_d;
  logic              err_q, err_d;
  logic [1:0]        op_code_q, op_code_d;
  logic              skip_q, skip_d;
  logic              dec_done;
  logic [1:0]        dec_op;

  modinv_invert_op_decode u_decode (
    .u_gt_v    (u_gt_v),
    .v_eq_1    (v_eq_1),
    .u_is_even (u_is_even),
    .v_is_even (v_is_even),
    .done      (dec_done),
    .op_code   (dec_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      err_q     <= 1'b0;
      op_code_q <= OP_HALVE_U;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      err_q     <= err_d;
      op_code_q <= op_code_d;
      skip_q    <= skip_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    err_d     = err_q;
    op_code_d = op_code_q;
    skip_d    = skip_q;
    cmp_ena   = 1'b0;
    op_ena    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ena) begin
          k_d     = '0;
          err_d   = 1'b0;
          state_d = ST_CMP_START;
        end
      end
      ST_CMP_START: begin
        if (cmp_rdy) begin
          cmp_ena = 1'b1;
          skip_d  = 1'b1;
          state_d = ST_CMP_WAIT;
        end
      end
      ST_CMP_WAIT: begin
        // skip_q masks the stale cmp_rdy seen in the cycle after the pulse
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (cmp_rdy) begin
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (dec_done) begin
          state_d = ST_IDLE;
        end
`ifdef MODINV_ITER_LIMIT_EN
        else if (k_q == K_BITS'(ITER_LIMIT)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
`endif
        else begin
          op_code_d = dec_op;
          state_d   = ST_OP_START;
        end
      end
      ST_OP_START: begin
        if (op_rdy) begin
          op_ena  = 1'b1;
          skip_d  = 1'b1;
          state_d = ST_OP_WAIT;
        end
      end
      ST_OP_WAIT: begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (op_rdy) begin
          k_d     = (k_q == K_MAX) ? k_q : k_q + 1'b1;
          state_d = ST_CMP_START;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rdy       = (state_q == ST_IDLE);
  assign k         = k_q;
  assign op_code   = op_code_q;
  assign state_dbg = state_q;
`ifdef MODINV_ITER_LIMIT_EN
  assign err = err_q;
`else
  // err_q is never set in this build, so the output is a constant zero
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_modinv_invert_loop_ctrl.sv
// Bench for modinv_invert_loop_ctrl: behavioural compare/op helpers with
// configurable latency, a model-fed op_code scoreboard and vector table.
module tb_modinv_invert_loop_ctrl;
  import modinv_invert_loop_ctrl_pkg::*;

  logic        clk, rst_n, ena, rdy, err;
  logic [9:0]  k;
  logic        cmp_ena, cmp_rdy, u_gt_v, v_eq_1, u_is_even, v_is_even;
  logic        op_ena, op_rdy;
  logic [1:0]  op_code;
  logic [2:0]  state_dbg;

  logic [31:0] u_val, v_val;
  int          cmp_delay, op_delay, cmp_cnt, op_cnt;
  int          n_cmp, n_op;
  logic        cmp_fired, op_fired;
  logic [1:0]  exp_q[$];
  logic [1:0]  obs_q[$];
  int          checks, errors;

  typedef struct {
    logic [31:0] u;
    logic [31:0] v;
    int          dcmp;
    int          dop;
    int          exp_k;
  } vec_t;

  modinv_invert_loop_ctrl #(.OPERAND_NUM_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rdy(rdy), .k(k), .err(err),
    .cmp_ena(cmp_ena), .cmp_rdy(cmp_rdy), .u_gt_v(u_gt_v), .v_eq_1(v_eq_1),
    .u_is_even(u_is_even), .v_is_even(v_is_even),
    .op_ena(op_ena), .op_code(op_code), .op_rdy(op_rdy), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign u_gt_v    = (u_val > v_val);
  assign v_eq_1    = (v_val == 32'd1);
  assign u_is_even = ~u_val[0];
  assign v_is_even = ~v_val[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference binary-GCD walk; pushes the op sequence the DUT must issue
  task automatic build_expect(input logic [31:0] u0, input logic [31:0] v0,
                              input int max_ops, output int n_ops);
    logic [31:0] u, v;
    u = u0; v = v0; n_ops = 0;
    while (v != 32'd1 && n_ops < max_ops) begin
      if (!u[0]) begin exp_q.push_back(2'd0); u = u >> 1; end
      else if (!v[0]) begin exp_q.push_back(2'd1); v = v >> 1; end
      else if (u > v) begin exp_q.push_back(2'd2); u = (u - v) >> 1; end
      else begin exp_q.push_back(2'd3); v = (v - u) >> 1; end
      n_ops++;
    end
  endtask

  always @(posedge clk) begin
    cmp_fired <= cmp_ena;
    op_fired  <= op_ena;
  end

  // helper responders + scoreboard, active on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      cmp_cnt = 0; op_cnt = 0; cmp_rdy = 1'b1; op_rdy = 1'b1;
    end else begin
      if (cmp_fired) begin
        n_cmp++;
        check("cmp_ena one cycle", {31'd0, cmp_ena}, 32'd0);
        cmp_cnt = cmp_delay;
      end else if (cmp_cnt > 0) cmp_cnt--;
      cmp_rdy = (cmp_cnt == 0);
      if (op_fired) begin
        n_op++;
        check("op_ena one cycle", {31'd0, op_ena}, 32'd0);
        obs_q.push_back(op_code);
        if (exp_q.size() == 0) begin
          check("unexpected op", 32'd1, 32'd0);
        end else begin
          check("op_code", {30'd0, op_code}, {30'd0, exp_q.pop_front()});
        end
        case (op_code)
          2'd0: u_val = u_val >> 1;
          2'd1: v_val = v_val >> 1;
          2'd2: u_val = (u_val - v_val) >> 1;
          default: v_val = (v_val - u_val) >> 1;
        endcase
        op_cnt = op_delay;
      end else if (op_cnt > 0) op_cnt--;
      op_rdy = (op_cnt == 0);
      if (cmp_ena || op_ena)
        check("ena one-hot", {31'd0, cmp_ena & op_ena}, 32'd0);
    end
  end

  // driver tasks: caller is at a negedge
  task automatic start_run(input logic [31:0] u0, input logic [31:0] v0,
                           input int dcmp, input int dop, input int max_ops,
                           output int n_ops);
    u_val = u0; v_val = v0; cmp_delay = dcmp; op_delay = dop;
    build_expect(u0, v0, max_ops, n_ops);
    n_cmp = 0; n_op = 0; obs_q.delete();
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output logic timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      if (rdy) begin timed_out = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t        vecs[7];
    logic [1:0]  ref_q[$];
    int          n;
    logic        to;
    logic        same;
    checks = 0; errors = 0;
    rst_n = 1'b0; ena = 1'b0; u_val = 32'd1; v_val = 32'd1;
    cmp_delay = 0; op_delay = 0; cmp_cnt = 0; op_cnt = 0;
    cmp_rdy = 1'b1; op_rdy = 1'b1; n_cmp = 0; n_op = 0;
    #3;
    check("reset rdy", {31'd0, rdy}, 32'd1);
    check("reset k", {22'd0, k}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset cmp_ena", {31'd0, cmp_ena}, 32'd0);
    check("reset op_ena", {31'd0, op_ena}, 32'd0);
    check("reset op_code", {30'd0, op_code}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle after reset", {31'd0, rdy}, 32'd1);
    check("no compare before ena", n_cmp, 0);

    vecs[0] = '{32'd7,  32'd3, 0,  0,  3};
    vecs[1] = '{32'd7,  32'd3, 20, 20, 3};
    vecs[2] = '{32'd4,  32'd1, 0,  0,  0};
    vecs[3] = '{32'd15, 32'd4, 0,  3,  2};
    vecs[4] = '{32'd12, 32'd7, 5,  0,  4};
    vecs[5] = '{32'd9,  32'd5, 1,  2,  4};
    vecs[6] = '{32'd1,  32'd1, 0,  0,  0};

    for (int i = 0; i < 7; i++) begin
      start_run(vecs[i].u, vecs[i].v, vecs[i].dcmp, vecs[i].dop, 1000, n);
      wait_done(4000, to);
      check("run finished", {31'd0, to}, 32'd0);
      check("k", {22'd0, k}, vecs[i].exp_k);
      check("err", {31'd0, err}, 32'd0);
      check("op count", n_op, n);
      check("compare count", n_cmp, vecs[i].exp_k + 1);
      check("scoreboard drained", exp_q.size(), 0);
      exp_q.delete();
      if (i == 0) ref_q = obs_q;
      if (i == 1) begin
        same = (ref_q.size() == obs_q.size());
        for (int j = 0; j < ref_q.size() && same; j++)
          if (ref_q[j] !== obs_q[j]) same = 1'b0;
        check("same ops at both latencies", {31'd0, same}, 32'd1);
      end
    end

    // back-to-back: ena in the cycle after rdy rises
    start_run(32'd7, 32'd3, 0, 0, 1000, n);
    wait_done(4000, to);
    check("b2b first run finished", {31'd0, to}, 32'd0);
    check("b2b first k", {22'd0, k}, 32'd3);
    start_run(32'd7, 32'd3, 0, 0, 1000, n);
    check("b2b restarted", {31'd0, rdy}, 32'd0);
    check("b2b k cleared", {22'd0, k}, 32'd0);
    wait_done(4000, to);
    check("b2b second run finished", {31'd0, to}, 32'd0);
    check("b2b second k", {22'd0, k}, 32'd3);
    check("b2b scoreboard drained", exp_q.size(), 0);
    exp_q.delete();

    // reset during OP_WAIT of the third op; ena while busy is ignored
    start_run(32'd7, 32'd3, 20, 20, 1000, n);
    to = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (n_op >= 3 && state_dbg == ST_OP_WAIT) begin to = 1'b0; break; end
      @(negedge clk);
    end
    check("reached third OP_WAIT", {31'd0, to}, 32'd0);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    check("busy ena ignored k", {22'd0, k}, 32'd2);
    check("busy rdy low", {31'd0, rdy}, 32'd0);
    check("op_code held", {30'd0, op_code}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async rst rdy", {31'd0, rdy}, 32'd1);
    check("async rst k", {22'd0, k}, 32'd0);
    check("async rst err", {31'd0, err}, 32'd0);
    check("async rst cmp_ena", {31'd0, cmp_ena}, 32'd0);
    check("async rst op_ena", {31'd0, op_ena}, 32'd0);
    check("async rst op_code", {30'd0, op_code}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle after mid reset", {31'd0, rdy}, 32'd1);
    check("no ops after mid reset", n_op, 3);

    // u=v=9 never converges: v collapses to 0
`ifdef MODINV_ITER_LIMIT_EN
    start_run(32'd9, 32'd9, 0, 0, 512, n);
    wait_done(8000, to);
    check("limit run finished", {31'd0, to}, 32'd0);
    check("limit err", {31'd0, err}, 32'd1);
    check("limit k", {22'd0, k}, 32'd512);
    check("limit op count", n_op, 512);
    check("limit scoreboard drained", exp_q.size(), 0);
    exp_q.delete();
`else
    start_run(32'd9, 32'd9, 0, 0, 600, n);
    to = 1'b1;
    for (int c = 0; c < 8000; c++) begin
      if (n_op >= 600) begin to = 1'b0; break; end
      if (rdy) break;
      @(negedge clk);
    end
    check("600 ops reached", {31'd0, to}, 32'd0);
    check("still running", {31'd0, rdy}, 32'd0);
    check("no abort", {31'd0, err}, 32'd0);
    check("k after 600 ops", {22'd0, k}, 32'd599);
    check("long scoreboard drained", exp_q.size(), 0);
    #1 rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
